// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the multi-port register file.
// Optional same-cycle write bypass is enabled by defining RF_WR_BYPASS_EN.
package rf_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DEPTH = 2 ** RF_AW;

  localparam int WP_ALU = 0;
  localparam int WP_LD  = 1;

  localparam int RF_MAXW = 256;

  // Extract field k of width w from a flattened port vector.
  function automatic logic [RF_MAXW-1:0] rf_slice(
    input logic [RF_MAXW-1:0] v,
    input int                 k,
    input int                 w
  );
    logic [RF_MAXW-1:0] m;
    m = (RF_MAXW'(1) << w) - RF_MAXW'(1);
    return (v >> (k * w)) & m;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for load-use hazard detection.
// Priority on one edge: flush, then load-completion clear, then set.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            clr,
  input  logic [AW-1:0]   clr_a,
  input  logic            bset,
  input  logic [AW-1:0]   bset_a,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]  rbusy
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             clr_ok;
  logic             set_ok;

  assign clr_ok = clr && !(ZERO_REG != 0 && clr_a == '0);
  assign set_ok = bset && !(ZERO_REG != 0 && bset_a == '0);

  always_comb begin
    busy_nxt = flush ? '0 : busy;
    if (clr_ok) busy_nxt[clr_a] = 1'b0;
    if (set_ok) busy_nxt[bset_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lk
    logic [AW-1:0] a;
    assign a = AW'(rf_slice(RF_MAXW'(ra), k, AW));
    assign rbusy[k] = busy[a] && !(ZERO_REG != 0 && a == '0);
  end

endmodule

// File: rtl/rf_mp_sb.sv
// rf_mp_sb: NRD-read / 2-write register file with busy scoreboard.
// Define RF_WR_BYPASS_EN to forward same-cycle writes to the read ports.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              bset,
  input  logic [AW-1:0]     bset_a,
  input  logic              flush
);

  localparam int DEPTH = 2 ** AW;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("rf_mp_sb: NRD must be in 1..4");
  end

  logic [DW-1:0] mem [DEPTH];
  logic          wok0;
  logic          wok1;

  assign wok0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wok1 = we1 && !(ZERO_REG != 0 && wa1 == '0);

  // Port 1 is written last so a load wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wok0) mem[wa0] <= wd0;
      if (wok1) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    assign a = AW'(rf_slice(RF_MAXW'(ra), k, AW));
    always_comb begin
      v = mem[a];
`ifdef RF_WR_BYPASS_EN
      if (we0 && wa0 == a) v = wd0;
      if (we1 && wa1 == a) v = wd1;
`else
`endif
      if (ZERO_REG != 0 && a == '0) v = '0;
    end
    assign rd[k*DW +: DW] = v;
  end

  rf_scoreboard #(
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .clr    (we1),
    .clr_a  (wa1),
    .bset   (bset),
    .bset_a (bset_a),
    .ra     (ra),
    .rbusy  (rbusy)
  );

endmodule

// File: tb/tb_rf_mp_sb.sv
// tb_rf_mp_sb: directed vectors for rf_mp_sb (default params, NRD=2).
// Expected values depend on whether RF_WR_BYPASS_EN is defined.
module tb_rf_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, bset, flush;
  logic [4:0]  wa0, wa1, bset_a;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;

  int ntests = 0;
  int nfail  = 0;

`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  rf_mp_sb dut (
    .clk    (clk),
    .rst    (rst),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .ra     (ra),
    .rd     (rd),
    .rbusy  (rbusy),
    .bset   (bset),
    .bset_a (bset_a),
    .flush  (flush)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; we0 = 0; we1 = 0; bset = 0; flush = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; bset_a = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdp(input logic [4:0] a0, input logic [4:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  initial begin
    idle();
    ra = '0;
    rst = 1;
    tick();
    // reset mid-operation: write and bset ignored
    we0 = 1; wa0 = 3; wd0 = 32'h55;
    bset = 1; bset_a = 4;
    tick();
    idle();
    rdp(3, 4);
    check("rst_rd3", rd[31:0], 32'h0);
    check("rst_busy4", {31'b0, rbusy[1]}, 32'h0);

    // plain write, next-cycle visibility
    we0 = 1; wa0 = 3; wd0 = 32'h55;
    tick();
    idle();
    rdp(3, 0);
    check("wr_rd3", rd[31:0], 32'h55);
    check("rd_zero_p1", rd[63:32], 32'h0);

    // collision: load port wins
    we0 = 1; wa0 = 7; wd0 = 32'h11;
    we1 = 1; wa1 = 7; wd1 = 32'h22;
    tick();
    idle();
    rdp(7, 3);
    check("coll_rd7", rd[31:0], 32'h22);
    check("coll_rd3", rd[63:32], 32'h55);

    // independent dual write
    we0 = 1; wa0 = 11; wd0 = 32'h1234;
    we1 = 1; wa1 = 10; wd1 = 32'hA5A5;
    tick();
    idle();
    rdp(10, 11);
    check("dual_rd10", rd[31:0], 32'hA5A5);
    check("dual_rd11", rd[63:32], 32'h1234);

    // bypass on port 0
    rdp(5, 3);
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    #1;
    check("byp_we0", rd[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    check("byp_other", rd[63:32], 32'h55);
    tick();
    idle();
    #1;
    check("after_we0", rd[31:0], 32'hDEADBEEF);

    // bypass priority: we1 over we0
    we0 = 1; wa0 = 5; wd0 = 32'h1;
    we1 = 1; wa1 = 5; wd1 = 32'h2;
    #1;
    check("byp_pri", rd[31:0], BYP ? 32'h2 : 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("after_pri", rd[31:0], 32'h2);

    // rbusy is not bypassed by same-cycle we1
    bset = 1; bset_a = 12;
    tick();
    idle();
    rdp(0, 12);
    check("busy12_set", {31'b0, rbusy[1]}, 32'h1);
    we1 = 1; wa1 = 12; wd1 = 32'h77;
    #1;
    check("busy12_nobyp", {31'b0, rbusy[1]}, 32'h1);
    tick();
    idle();
    #1;
    check("busy12_clr", {31'b0, rbusy[1]}, 32'h0);
    check("rd12", rd[63:32], 32'h77);

    // zero register
    rdp(0, 0);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
    bset = 1; bset_a = 0;
    #1;
    check("z_rd_now", rd[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("z_rd", rd[31:0], 32'h0);
    check("z_busy", {30'b0, rbusy}, 32'h0);
    tick();
    check("z_rd_later", rd[63:32], 32'h0);
    check("z_busy_later", {30'b0, rbusy}, 32'h0);

    // scoreboard priority
    bset = 1; bset_a = 9;
    tick();
    idle();
    rdp(9, 9);
    check("sb_set9", {31'b0, rbusy[0]}, 32'h1);
    we1 = 1; wa1 = 9; wd1 = 32'h99;
    bset = 1; bset_a = 9;
    tick();
    idle();
    #1;
    check("sb_setwins", {31'b0, rbusy[0]}, 32'h1);
    we1 = 1; wa1 = 9; wd1 = 32'h98;
    tick();
    idle();
    #1;
    check("sb_clr9", {31'b0, rbusy[0]}, 32'h0);

    // flush with concurrent bset
    bset = 1; bset_a = 2;
    tick();
    bset_a = 6;
    tick();
    bset_a = 8;
    tick();
    idle();
    rdp(2, 8);
    check("fl_pre", {30'b0, rbusy}, 32'h3);
    flush = 1; bset = 1; bset_a = 6;
    tick();
    idle();
    rdp(2, 6);
    check("fl_r2_r6", {30'b0, rbusy}, 32'h2);
    rdp(8, 9);
    check("fl_r8_r9", {30'b0, rbusy}, 32'h0);

    // reset after activity clears data and busy
    rst = 1; we0 = 1; wa0 = 3; wd0 = 32'hAA;
    tick();
    idle();
    rdp(3, 6);
    check("rst2_rd3", rd[31:0], 32'h0);
    check("rst2_busy6", {31'b0, rbusy[1]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
Parametrised multi-port register file for the pipelined core.
- NRD combinational read ports, two write ports: port 0 for ALU writeback, port 1 for load writeback.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for load-use hazard detection.
- Sits between decode (reads, busy query) and writeback (writes, busy clear).

Parameters:
DW, 32, data width in bits
AW, 5, register address width; depth = 2**AW
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
we0  in  1  write enable, port 0 (ALU writeback)
wa0  in  AW  write address, port 0
wd0  in  DW  write data, port 0
we1  in  1  write enable, port 1 (load writeback); also clears busy[wa1]
wa1  in  AW  write address, port 1
wd1  in  DW  write data, port 1
ra  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd  out  NRD*DW  read data, port k at bits [k*DW +: DW]
rbusy  out  NRD  busy flag of register addressed by read port k
bset  in  1  mark register busy (load issued)
bset_a  in  AW  register to mark busy
flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: on a clk edge with rst=1, all registers and all busy bits become 0. Writes, bset and flush in that cycle are ignored.
- Writes: take effect on the rising edge, visible to reads the next cycle.
- Same-address writes: if we0 and we1 target the same address in one cycle, port 1 (load) wins.
- Reads: combinational, zero latency. If ZERO_REG=1 and the address is 0, rd=0 and rbusy=0.
- Zero register: with ZERO_REG=1, writes and bset to address 0 are ignored. With ZERO_REG=0, register 0 behaves like any other.
- Busy bits, priority within one edge:
  - flush clears all bits first.
  - Then we1 clears busy[wa1].
  - Then bset sets busy[bset_a].
  - Result: bset on the same address as we1 leaves the bit set (new load supersedes the completed one). bset together with flush leaves only busy[bset_a] set.
- rbusy: reflects registered busy state only. It is not bypassed by a same-cycle we1.
- Out-of-range NRD: elaboration fails via a generate-time check.

Optional Feature:
Macro: RF_WR_BYPASS_EN
- Defined: a read whose address matches an active write in the same cycle returns that write data. we1 has priority over we0. Zero-register rules still apply.
- Undefined: reads always return the stored value. A write becomes visible the cycle after the edge.

Decomposition:
- Package rf_pkg:
  - default DW/AW constants
  - localparam DEPTH = 2**AW
  - write-port index constants WP_ALU=0, WP_LD=1
  - function to slice a flattened port vector
- Sub-module rf_scoreboard:
  - owns the DEPTH-bit busy vector
  - handles flush/clear/set priority
  - provides NRD lookup outputs
- Top module holds the storage array, write arbitration and bypass muxing.

Test Plan:
1. Reset mid-operation: rst=1 with we0=1 wa0=3 wd0=0x55 and bset=1 bset_a=4 -> next cycle rd(ra=3)=0, rbusy(ra=4)=0.
2. Dual write collision: we0 wa0=7 wd0=0x11 and we1 wa1=7 wd1=0x22 -> next cycle rd(ra=7)=0x22.
3. Bypass: we0 wa0=5 wd0=0xDEADBEEF while ra0=5 in the same cycle -> rd0=0xDEADBEEF with the macro defined, old value (0) without it.
4. Zero register (ZERO_REG=1): we0 wa0=0 wd0=0xFFFFFFFF and bset_a=0 -> rd(ra=0)=0, rbusy=0 in all later cycles.
5. Scoreboard priority: bset_a=9, next cycle rbusy(ra=9)=1. Then we1 wa1=9 with bset bset_a=9 -> rbusy stays 1. Then we1 wa1=9 alone -> rbusy=0.
6. Flush: busy set on regs 2, 6, 8; flush=1 with bset bset_a=6 -> next cycle rbusy=1 only for reg 6.
